pll_acq_ctrl: RTL
=================

# pll_acq_ctrl

Acquisition and lock sequencer for the SWIPT phase-locked loop. It brings the loop from idle to lock and supervises it while locked. It seeds the loop's centre frequency with a coarse sweep across F0±DELF, gates the loop's run enable, and qualifies lock from per-edge phase-error samples. It sits between the SWIPT link supervisor and the PLL core; the core reports phase error, and this block drives `pll_run` and `f_seed`.

## Interface
- `F0`, 32'h9C40: nominal frequency in Hz (40 kHz).
- `DELF`, 32'h1388: sweep half-span in Hz (5 kHz).
- `STEP`, 32'd500: sweep increment in Hz.
- `CAPTURE_THR`, 32'd64: phase-error magnitude, in clk cycles, below which capture is declared.
- `LOCK_THR`, 32'd8: phase-error magnitude, in clk cycles, below which a sample counts as "good".
- `LOCK_CNT`, 8: consecutive good samples required to declare lock.
- `LOSS_CNT`, 4: consecutive bad samples required to drop lock.
- `SETTLE_CYC`, 256: clk cycles spent in SETTLE.
- `MAX_PASS`, 3: full sweep passes allowed before FAULT.
- `TIMEOUT_CYC`, 100000: link-edge watchdog period in clk cycles.

Ports:
- `clk` input 1: system clock; all state on posedge.
- `nrst` input 1: asynchronous, active-low reset.
- `enable` input 1: acquisition request.
- `swiptAlive` input 1: power link present.
- `link_edge` input 1: single-cycle pulse per reference edge, already synchronised to `clk`.
- `err_valid` input 1: single-cycle strobe; qualifies `err_mag`.
- `err_mag` input 32: unsigned phase error in clk cycles.
- `pll_run` output 1: enables the PLL frequency update.
- `f_seed` output 32: centre frequency in Hz for the PLL.
- `locked` output 1: lock qualified.
- `fault` output 1: acquisition failed.
- `state` output 3: encoded FSM state.

## Operation
- FSM states: IDLE=0, SWEEP=1, SETTLE=2, TRACK=3, LOCKED=4, FAULT=5.
- IDLE:
  - `pll_run`=0 and `f_seed`=F0; all counters are cleared.
  - Goes to SWEEP when `enable` and `swiptAlive` are both high. `f_seed` is loaded with F0−DELF on that transition.
- SWEEP:
  - `pll_run`=0.
  - On `err_valid` with `err_mag` < CAPTURE_THR: go to SETTLE and hold `f_seed`.
  - On `err_valid` with `err_mag` ≥ CAPTURE_THR: `f_seed` += STEP.
  - If the new value would exceed F0+DELF, `f_seed` wraps to F0−DELF and `pass` increments. The pass counter is 3 bits and saturates.
  - When `pass` reaches MAX_PASS, go to FAULT.
- SETTLE: `pll_run`=1; error samples are ignored. Go to TRACK after SETTLE_CYC cycles.
- TRACK:
  - `pll_run`=1.
  - Each sample with `err_mag` < LOCK_THR increments `good`; any other sample clears `good`.
  - When `good` reaches LOCK_CNT, go to LOCKED.
  - Any sample with `err_mag` ≥ CAPTURE_THR returns to SWEEP, resuming from the current `f_seed` with `pass` unchanged.
- LOCKED:
  - `locked`=1.
  - Each sample with `err_mag` ≥ LOCK_THR increments `bad`; a good sample clears `bad`.
  - When `bad` reaches LOSS_CNT, go to TRACK with `good` cleared.
- FAULT: `fault`=1, `pll_run`=0, `f_seed` holds. Exits to IDLE only when `enable` is low.
- Priority when events coincide, highest first:
  1. `enable` or `swiptAlive` low: go to IDLE from any state except FAULT.
  2. Watchdog expiry (see Configuration).
  3. `err_valid` action.
  4. SETTLE count expiry.
- All arithmetic is 32-bit unsigned. The comparison against F0+DELF is done on a 33-bit sum, so no overflow aliasing is possible.

## Timing
- Reset values: `state`=IDLE, `f_seed`=F0, `pll_run`=0, `locked`=0, `fault`=0.
- All outputs are registered and change on the clk edge following the event that causes them.
- Latencies:
  - `err_valid` → state or `f_seed` update: 1 cycle.
  - Deassertion of `enable` or `swiptAlive` → IDLE outputs: 1 cycle.
- `locked` is high only in LOCKED and falls on the same edge as the exit transition.
- If `err_valid` arrives on the same cycle as the SETTLE→TRACK transition, that sample is discarded.
- Reset asserted mid-operation forces reset values immediately, asynchronously.

## Configuration
- `PLL_ACQ_TIMEOUT_EN` defined:
  - A 32-bit watchdog counts clk cycles since the last `link_edge`. It is cleared by `link_edge` and while in IDLE or FAULT.
  - Reaching TIMEOUT_CYC in SWEEP, SETTLE, TRACK or LOCKED forces IDLE.
- `PLL_ACQ_TIMEOUT_EN` undefined: no watchdog; `link_edge` is unused.

## Test plan
- Reset and idle: release `nrst` with `enable`=0, then raise `enable`=1 and `swiptAlive`=1.
  - Expect `f_seed`=40000 and `state`=0 immediately after reset release.
  - Expect `state`=1 and `f_seed`=35000 one cycle after `enable` rises.
- Sweep then capture: send samples with `err_mag`=100 three times, then one with `err_mag`=20.
  - Expect `f_seed` to step 35500 → 36000 → 36500 and then hold.
  - Expect `state`=2 and `pll_run`=1.
- Lock then loss:
  - After SETTLE, eight samples with `err_mag`=3 → `locked`=1 on the 8th sample.
  - Then four samples with `err_mag`=10 → `locked`=0 and `state`=3.
- Wrap and fault: send continuous samples with `err_mag`=100.
  - Expect `f_seed` to wrap from 45000 to 35000 at the end of each pass.
  - After 3 passes expect `fault`=1; drop `enable` → `state`=0.
- Abort: drop `swiptAlive` in LOCKED while `err_valid` is high on the same cycle.
  - Expect IDLE next cycle with `locked`=0 and `f_seed`=40000.
- Watchdog: with `PLL_ACQ_TIMEOUT_EN` defined and TIMEOUT_CYC=1000, send no `link_edge` while in TRACK.
  - Expect IDLE at cycle 1000.
  - Without the macro, expect the block to stay in TRACK.

Source files
------------

// File: rtl/pll_acq_ctrl.sv
// rtl/pll_acq_ctrl.sv - PLL acquisition/lock sequencer (optional watchdog: PLL_ACQ_TIMEOUT_EN)
module pll_acq_ctrl #(
    parameter logic [31:0] F0          = 32'h9C40,
    parameter logic [31:0] DELF        = 32'h1388,
    parameter logic [31:0] STEP        = 32'd500,
    parameter logic [31:0] CAPTURE_THR = 32'd64,
    parameter logic [31:0] LOCK_THR    = 32'd8,
    parameter int          LOCK_CNT    = 8,
    parameter int          LOSS_CNT    = 4,
    parameter int          SETTLE_CYC  = 256,
    parameter int          MAX_PASS    = 3,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enable,
    input  logic        swiptAlive,
    input  logic        link_edge,
    input  logic        err_valid,
    input  logic [31:0] err_mag,
    output logic        pll_run,
    output logic [31:0] f_seed,
    output logic        locked,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SWEEP  = 3'd1,
        S_SETTLE = 3'd2,
        S_TRACK  = 3'd3,
        S_LOCKED = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [7:0]  LOCK_CNT_V  = 8'(LOCK_CNT);
    localparam logic [7:0]  LOSS_CNT_V  = 8'(LOSS_CNT);
    localparam logic [2:0]  MAX_PASS_V  = 3'(MAX_PASS);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] SEED_LO     = F0 - DELF;
    localparam logic [32:0] SEED_HI     = {1'b0, F0} + {1'b0, DELF};

    state_t      cur, nxt;
    logic [31:0] seed_n;
    logic [2:0]  pass, pass_n, pass_inc;
    logic [7:0]  good, good_n, bad, bad_n;
    logic [31:0] settle_cnt, settle_n;
    logic        timeout;
    logic [32:0] seed_sum;

    assign state    = cur;
    assign seed_sum = {1'b0, f_seed} + {1'b0, STEP};
    assign pass_inc = (pass == 3'd7) ? pass : pass + 3'd1;

`ifdef PLL_ACQ_TIMEOUT_EN
    logic [31:0] wdog, wdog_n;
    logic        active;

    assign active = (cur == S_SWEEP) || (cur == S_SETTLE) ||
                    (cur == S_TRACK) || (cur == S_LOCKED);

    // Watchdog: cycles since the last reference edge while acquiring or locked
    always_comb begin
        wdog_n  = 32'd0;
        timeout = 1'b0;
        if (active && !link_edge) begin
            wdog_n  = wdog + 32'd1;
            timeout = (wdog_n >= TIMEOUT_CYC);
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) wdog <= 32'd0;
        else       wdog <= wdog_n;
    end
`else
    logic unused_link_edge;
    assign unused_link_edge = link_edge;
    assign timeout          = 1'b0;
`endif

    // Next-state, seed and counter logic; aborts override the per-state action
    always_comb begin
        nxt      = cur;
        seed_n   = f_seed;
        pass_n   = pass;
        good_n   = good;
        bad_n    = bad;
        settle_n = settle_cnt;
        case (cur)
            S_IDLE: begin
                if (enable && swiptAlive) begin
                    nxt    = S_SWEEP;
                    seed_n = SEED_LO;
                end
            end
            S_SWEEP: begin
                if (err_valid) begin
                    if (err_mag < CAPTURE_THR) begin
                        nxt      = S_SETTLE;
                        settle_n = 32'd0;
                    end else if (seed_sum > SEED_HI) begin
                        seed_n = SEED_LO;
                        pass_n = pass_inc;
                        if (pass_inc >= MAX_PASS_V) nxt = S_FAULT;
                    end else begin
                        seed_n = seed_sum[31:0];
                    end
                end
            end
            S_SETTLE: begin
                // samples here are ignored, including on the exit cycle
                if (settle_cnt == SETTLE_LAST) begin
                    nxt    = S_TRACK;
                    good_n = 8'd0;
                end else begin
                    settle_n = settle_cnt + 32'd1;
                end
            end
            S_TRACK: begin
                if (err_valid) begin
                    if (err_mag >= CAPTURE_THR) begin
                        nxt    = S_SWEEP;
                        good_n = 8'd0;
                    end else if (err_mag < LOCK_THR) begin
                        good_n = good + 8'd1;
                        if (good_n == LOCK_CNT_V) begin
                            nxt   = S_LOCKED;
                            bad_n = 8'd0;
                        end
                    end else begin
                        good_n = 8'd0;
                    end
                end
            end
            S_LOCKED: begin
                if (err_valid) begin
                    if (err_mag >= LOCK_THR) begin
                        bad_n = bad + 8'd1;
                        if (bad_n == LOSS_CNT_V) begin
                            nxt    = S_TRACK;
                            good_n = 8'd0;
                            bad_n  = 8'd0;
                        end
                    end else begin
                        bad_n = 8'd0;
                    end
                end
            end
            S_FAULT: begin
                if (!enable) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase

        if (cur != S_FAULT && (!enable || !swiptAlive)) nxt = S_IDLE;
        else if (timeout)                               nxt = S_IDLE;

        if (nxt == S_IDLE) begin
            seed_n   = F0;
            pass_n   = 3'd0;
            good_n   = 8'd0;
            bad_n    = 8'd0;
            settle_n = 32'd0;
        end
    end

    // State, counters and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cur        <= S_IDLE;
            f_seed     <= F0;
            pass       <= 3'd0;
            good       <= 8'd0;
            bad        <= 8'd0;
            settle_cnt <= 32'd0;
            pll_run    <= 1'b0;
            locked     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            cur        <= nxt;
            f_seed     <= seed_n;
            pass       <= pass_n;
            good       <= good_n;
            bad        <= bad_n;
            settle_cnt <= settle_n;
            pll_run    <= (nxt == S_SETTLE) || (nxt == S_TRACK) || (nxt == S_LOCKED);
            locked     <= (nxt == S_LOCKED);
            fault      <= (nxt == S_FAULT);
        end
    end

endmodule
